// File: rtl/stroke_arbiter_if.sv
// Frame-buffer write port: one pixel beat per transfer, valid/ready handshake.
interface stroke_arbiter_if;
  logic        wr_en_out;
  logic [15:0] wr_addr_out;
  logic [3:0]  wr_data_out;
  logic        wr_ready_in;

  modport master (output wr_en_out, wr_addr_out, wr_data_out, input wr_ready_in);
  modport slave  (input wr_en_out, wr_addr_out, wr_data_out, output wr_ready_in);
endinterface

// File: rtl/stroke_arbiter.sv
// Paints the brush footprints of two stroke sources into a frame buffer once per
// frame, alternating which source goes first and skipping unchanged strokes.
module stroke_arbiter #(
  parameter int unsigned H_RES = 320,
  parameter int unsigned V_RES = 180
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             nf_in,
  input  logic             draw1_in,
  input  logic             draw2_in,
  input  logic [9:0]       x1_in,
  input  logic [9:0]       x2_in,
  input  logic [8:0]       y1_in,
  input  logic [8:0]       y2_in,
  input  logic [3:0]       color1_in,
  input  logic [3:0]       color2_in,
  input  logic [2:0]       sw1_in,
  input  logic [2:0]       sw2_in,
  stroke_arbiter_if.master wr_bus,
  output logic             busy_out,
  output logic             done_out,
  output logic [7:0]       drop_count_out
);

  typedef enum logic [2:0] {IDLE, LATCH, SELECT, PAINT, NEXT_SRC, FINISH} state_t;

  localparam logic [15:0] H_RES_W = 16'(H_RES);

  state_t state, state_d;

  // Per-source latched stroke, index 0 = source 1, index 1 = source 2
  logic [1:0]       draw_q;
  logic [1:0][9:0]  x_q;
  logic [1:0][8:0]  y_q;
  logic [1:0][3:0]  col_q;
  logic [1:0][2:0]  sw_q;
  logic [1:0][25:0] last_tuple;
  logic [1:0]       last_valid;

  logic       first_src, cur_src, second_src;
  logic [2:0] dx, dy;

  logic [9:0]  cur_x;
  logic [8:0]  cur_y;
  logic [3:0]  cur_col;
  logic [2:0]  cur_sw;
  logic [25:0] cur_tuple;
  logic [10:0] px;
  logic [9:0]  py;
  logic        in_canvas, last_pix, skip_src, step;
  logic [15:0] row_base, pix_addr;

  assign cur_x     = x_q[cur_src];
  assign cur_y     = y_q[cur_src];
  assign cur_col   = col_q[cur_src];
  assign cur_sw    = sw_q[cur_src];
  assign cur_tuple = {cur_x, cur_y, cur_col, cur_sw};

  assign px        = {1'b0, cur_x} + {8'd0, dx};
  assign py        = {1'b0, cur_y} + {7'd0, dy};
  assign in_canvas = (32'(px) < H_RES) && (32'(py) < V_RES);
  assign last_pix  = (dx == cur_sw) && (dy == cur_sw);
  assign skip_src  = !draw_q[cur_src] ||
                     (last_valid[cur_src] && (cur_tuple == last_tuple[cur_src]));

  // Row offset as a sum of shifted copies of py, one per set bit of H_RES
  always_comb begin
    row_base = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (H_RES_W[i[3:0]]) row_base = row_base + (16'(py) << i);
    end
    pix_addr = row_base + 16'(px);
  end

  assign busy_out = (state != IDLE);

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d            = state;
    step               = 1'b0;
    done_out           = 1'b0;
    wr_bus.wr_en_out   = 1'b0;
    wr_bus.wr_addr_out = '0;
    wr_bus.wr_data_out = '0;
    case (state)
      IDLE:     if (nf_in) state_d = LATCH;
      LATCH:    state_d = SELECT;
      SELECT:   state_d = skip_src ? NEXT_SRC : PAINT;
      PAINT: begin
        if (in_canvas) begin
          wr_bus.wr_en_out   = 1'b1;
          wr_bus.wr_addr_out = pix_addr;
          wr_bus.wr_data_out = cur_col;
          step               = wr_bus.wr_ready_in;
        end else begin
          step = 1'b1;
        end
        if (step && last_pix) state_d = NEXT_SRC;
      end
      NEXT_SRC: state_d = second_src ? FINISH : SELECT;
      FINISH: begin
        done_out = 1'b1;
        state_d  = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      draw_q         <= '0;
      x_q            <= '0;
      y_q            <= '0;
      col_q          <= '0;
      sw_q           <= '0;
      last_tuple     <= '0;
      last_valid     <= '0;
      first_src      <= 1'b0;
      cur_src        <= 1'b0;
      second_src     <= 1'b0;
      dx             <= '0;
      dy             <= '0;
      drop_count_out <= '0;
    end else begin
      if (state == IDLE && nf_in) begin
        draw_q <= {draw2_in, draw1_in};
        x_q    <= {x2_in, x1_in};
        y_q    <= {y2_in, y1_in};
        col_q  <= {color2_in, color1_in};
        sw_q   <= {sw2_in, sw1_in};
      end
      if (state == LATCH) begin
        cur_src    <= first_src;
        second_src <= 1'b0;
      end
      if (state == SELECT) begin
        dx <= '0;
        dy <= '0;
      end
      if (state == PAINT && step) begin
        if (last_pix) begin
          last_tuple[cur_src] <= cur_tuple;
          last_valid[cur_src] <= 1'b1;
        end else if (dx == cur_sw) begin
          dx <= '0;
          dy <= dy + 3'd1;
        end else begin
          dx <= dx + 3'd1;
        end
      end
      if (state == NEXT_SRC && !second_src) begin
        cur_src    <= ~cur_src;
        second_src <= 1'b1;
      end
      if (state == FINISH) first_src <= ~first_src;
      if (nf_in && state != IDLE && drop_count_out != 8'hFF)
        drop_count_out <= drop_count_out + 8'd1;
    end
  end

endmodule

// File: tb/tb_stroke_arbiter.sv
// Bench for stroke_arbiter: scenario tasks plus randomized rounds checked against
// a per-frame model that lists the expected pixel writes for each round.
module tb_stroke_arbiter;
  localparam int H = 320;
  localparam int V = 180;

  typedef struct packed {
    logic       draw;
    logic [9:0] x;
    logic [8:0] y;
    logic [3:0] col;
    logic [2:0] sw;
  } src_t;

  logic buffered_clk_100mhz = 1'b0;
  always #5 buffered_clk_100mhz = ~buffered_clk_100mhz;

  logic       rst, nf, draw1, draw2;
  logic [9:0] x1, x2;
  logic [8:0] y1, y2;
  logic [3:0] color1, color2;
  logic [2:0] sw1, sw2;
  logic       busy, done;
  logic [7:0] drop_count;

  stroke_arbiter_if wr_bus ();

  stroke_arbiter #(.H_RES(H), .V_RES(V)) dut (
    .clk_in(buffered_clk_100mhz), .rst_in(rst), .nf_in(nf),
    .draw1_in(draw1), .draw2_in(draw2), .x1_in(x1), .x2_in(x2),
    .y1_in(y1), .y2_in(y2), .color1_in(color1), .color2_in(color2),
    .sw1_in(sw1), .sw2_in(sw2), .wr_bus(wr_bus),
    .busy_out(busy), .done_out(done), .drop_count_out(drop_count)
  );

  int total = 0;
  int bad   = 0;
  logic [19:0] got_q[$];
  logic [19:0] exp_q[$];
  int done_cnt = 0;

  int   m_first;
  bit   m_valid[2];
  src_t m_last[2];
  int   m_drops;

  always @(negedge buffered_clk_100mhz) begin
    if (wr_bus.wr_en_out === 1'b1 && wr_bus.wr_ready_in === 1'b1)
      got_q.push_back({wr_bus.wr_addr_out, wr_bus.wr_data_out});
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge buffered_clk_100mhz);
    #1;
  endtask

  function automatic src_t mk(input bit d, input int x, input int y, input int c, input int w);
    src_t s;
    s.draw = d; s.x = 10'(x); s.y = 9'(y); s.col = 4'(c); s.sw = 3'(w);
    return s;
  endfunction

  function automatic void model_reset();
    m_first = 0; m_valid[0] = 0; m_valid[1] = 0; m_drops = 0;
  endfunction

  // Expected writes of one round: each source in turn, its square footprint row by row
  function automatic void model_round(input src_t a, input src_t b);
    src_t s[2];
    s[0] = a; s[1] = b;
    exp_q.delete();
    for (int k = 0; k < 2; k++) begin
      int i;
      i = (m_first + k) % 2;
      if (s[i].draw && !(m_valid[i] && s[i].x == m_last[i].x && s[i].y == m_last[i].y &&
                         s[i].col == m_last[i].col && s[i].sw == m_last[i].sw)) begin
        for (int yy = 0; yy <= int'(s[i].sw); yy++)
          for (int xx = 0; xx <= int'(s[i].sw); xx++)
            if (int'(s[i].x) + xx < H && int'(s[i].y) + yy < V)
              exp_q.push_back({16'((int'(s[i].y) + yy) * H + int'(s[i].x) + xx), s[i].col});
        m_last[i]  = s[i];
        m_valid[i] = 1;
      end
    end
    m_first = 1 - m_first;
  endfunction

  task automatic set_inputs(input src_t a, input src_t b);
    draw1 = a.draw; x1 = a.x; y1 = a.y; color1 = a.col; sw1 = a.sw;
    draw2 = b.draw; x2 = b.x; y2 = b.y; color2 = b.col; sw2 = b.sw;
  endtask

  task automatic scramble();
    draw1 = 1'($urandom); x1 = 10'($urandom); y1 = 9'($urandom); color1 = 4'($urandom); sw1 = 3'($urandom);
    draw2 = 1'($urandom); x2 = 10'($urandom); y2 = 9'($urandom); color2 = 4'($urandom); sw2 = 3'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1; nf = 1'b0; wr_bus.wr_ready_in = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    model_reset();
  endtask

  task automatic run_round(input src_t a, input src_t b, input int ready_pct, input bit extra_nf,
                           output int gb, output int nb, output int nd, output bit to);
    int db;
    model_round(a, b);
    gb = got_q.size(); db = done_cnt;
    set_inputs(a, b);
    nf = 1'b1;
    tick();
    if (extra_nf) begin
      tick();
      m_drops = (m_drops < 255) ? m_drops + 1 : 255;
    end
    nf = 1'b0;
    scramble();
    to = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      wr_bus.wr_ready_in = (int'($urandom_range(99)) < ready_pct);
      tick();
      if (done_cnt != db) begin to = 1'b0; break; end
    end
    wr_bus.wr_ready_in = 1'b1;
    repeat (3) tick();
    nb = got_q.size() - gb; nd = done_cnt - db;
  endtask

  task automatic test_reset();
    rst = 1'b1; nf = 1'b1; wr_bus.wr_ready_in = 1'b1;
    set_inputs(mk(1, 1, 1, 1, 1), mk(1, 2, 2, 2, 2));
    tick();
    total++; if (wr_bus.wr_en_out !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %b want 0", wr_bus.wr_en_out); end
    total++; if (wr_bus.wr_addr_out !== 16'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", wr_bus.wr_addr_out); end
    total++; if (wr_bus.wr_data_out !== 4'd0) begin bad++; $display("FAIL reset_data: got %0d want 0", wr_bus.wr_data_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    rst = 1'b0; nf = 1'b0;
    tick();
    model_reset();
  endtask

  task automatic test_single();
    int gb, nb, nd; bit to;
    run_round(mk(1, 10, 5, 7, 0), mk(0, 40, 40, 3, 2), 100, 0, gb, nb, nd, to);
    total++; if (to || nd !== 1) begin bad++; $display("FAIL single_done: pulses %0d timeout %0d want 1 pulse", nd, to); end
    total++; if (nb !== 1 || got_q[gb] !== {16'd1610, 4'd7})
      begin bad++; $display("FAIL single_beat: beats %0d first addr %0d data %0d want 1 beat addr 1610 data 7", nb, got_q[gb][19:4], got_q[gb][3:0]); end
  endtask

  task automatic test_two_sources();
    int gb, nb, nd; bit to;
    int want1[5];
    want1 = '{0, 1, 320, 321, 32100};
    do_reset();
    run_round(mk(1, 0, 0, 3, 1), mk(1, 100, 100, 9, 0), 100, 0, gb, nb, nd, to);
    total++; if (to || nd !== 1 || nb !== 5) begin bad++; $display("FAIL two_r1_count: beats %0d pulses %0d want 5 beats 1 pulse", nb, nd); end
    for (int i = 0; i < 5 && i < nb; i++) begin
      total++;
      if (int'(got_q[gb+i][19:4]) !== want1[i]) begin bad++; $display("FAIL two_r1_addr[%0d]: got %0d want %0d", i, got_q[gb+i][19:4], want1[i]); end
    end
    run_round(mk(1, 5, 5, 2, 0), mk(1, 200, 50, 4, 0), 100, 0, gb, nb, nd, to);
    total++; if (to || nd !== 1 || nb !== 2) begin bad++; $display("FAIL two_r2_count: beats %0d pulses %0d want 2 beats 1 pulse", nb, nd); end
    total++; if (got_q[gb] !== {16'd16200, 4'd4} || got_q[gb+1] !== {16'd1605, 4'd2})
      begin bad++; $display("FAIL two_r2_order: got addrs %0d,%0d want 16200,1605", got_q[gb][19:4], got_q[gb+1][19:4]); end
  endtask

  task automatic test_clipping();
    int gb, nb, nd; bit to;
    int want[4];
    want = '{57278, 57279, 57598, 57599};
    run_round(mk(1, 318, 178, 5, 3), mk(0, 0, 0, 0, 0), 100, 0, gb, nb, nd, to);
    total++; if (to || nd !== 1 || nb !== 4) begin bad++; $display("FAIL clip_count: beats %0d pulses %0d want 4 beats 1 pulse", nb, nd); end
    for (int i = 0; i < 4 && i < nb; i++) begin
      total++;
      if (got_q[gb+i] !== {16'(want[i]), 4'd5}) begin bad++; $display("FAIL clip_beat[%0d]: got addr %0d data %0d want addr %0d data 5", i, got_q[gb+i][19:4], got_q[gb+i][3:0], want[i]); end
    end
  endtask

  task automatic test_backpressure();
    int gb, db, stalls; bit to;
    logic [19:0] held;
    model_round(mk(1, 20, 30, 6, 1), mk(0, 0, 0, 0, 0));
    gb = got_q.size(); db = done_cnt;
    set_inputs(mk(1, 20, 30, 6, 1), mk(0, 0, 0, 0, 0));
    nf = 1'b1; tick(); nf = 1'b0; scramble();
    stalls = 0; to = 1'b1; held = '0;
    for (int c = 0; c < 300; c++) begin
      if (stalls > 0 && stalls < 5) begin
        total++;
        if (wr_bus.wr_en_out !== 1'b1 || {wr_bus.wr_addr_out, wr_bus.wr_data_out} !== held)
          begin bad++; $display("FAIL bp_stable: en %b addr %0d data %0d want en 1 addr %0d data %0d", wr_bus.wr_en_out, wr_bus.wr_addr_out, wr_bus.wr_data_out, held[19:4], held[3:0]); end
      end
      if (got_q.size() - gb == 1 && stalls == 0 && wr_bus.wr_en_out === 1'b1) begin
        held = {wr_bus.wr_addr_out, wr_bus.wr_data_out};
        wr_bus.wr_ready_in = 1'b0; stalls = 1;
      end else if (stalls > 0 && stalls < 5) begin
        wr_bus.wr_ready_in = 1'b0; stalls++;
      end else begin
        wr_bus.wr_ready_in = 1'b1;
      end
      tick();
      if (done_cnt != db) begin to = 1'b0; break; end
    end
    wr_bus.wr_ready_in = 1'b1;
    repeat (3) tick();
    total++; if (to || stalls !== 5 || held !== {16'd9621, 4'd6})
      begin bad++; $display("FAIL bp_stall_beat: timeout %0d stalls %0d held addr %0d want 5 stalls on addr 9621", to, stalls, held[19:4]); end
    total++; if (got_q.size() - gb !== exp_q.size()) begin bad++; $display("FAIL bp_count: got %0d beats want %0d", got_q.size() - gb, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && gb + i < got_q.size(); i++) begin
      total++;
      if (got_q[gb+i] !== exp_q[i]) begin bad++; $display("FAIL bp_beat[%0d]: got addr %0d want %0d", i, got_q[gb+i][19:4], exp_q[i][19:4]); end
    end
  endtask

  task automatic test_random();
    int gb, nb, nd; bit to;
    src_t a, b;
    do_reset();
    a = mk(0, 0, 0, 0, 0); b = a;
    for (int r = 0; r < 25; r++) begin
      if (!($urandom_range(2) == 0 && a.draw)) begin
        a.draw = ($urandom_range(3) != 0);
        a.x = ($urandom_range(3) == 0) ? 10'($urandom_range(300, 1023)) : 10'($urandom_range(0, 319));
        a.y = ($urandom_range(3) == 0) ? 9'($urandom_range(170, 511)) : 9'($urandom_range(0, 179));
        a.col = 4'($urandom); a.sw = 3'($urandom);
      end
      if (!($urandom_range(2) == 0 && b.draw)) begin
        b.draw = ($urandom_range(3) != 0);
        b.x = ($urandom_range(3) == 0) ? 10'($urandom_range(300, 1023)) : 10'($urandom_range(0, 319));
        b.y = ($urandom_range(3) == 0) ? 9'($urandom_range(170, 511)) : 9'($urandom_range(0, 179));
        b.col = 4'($urandom); b.sw = 3'($urandom);
      end
      run_round(a, b, 60, 1'($urandom_range(1)), gb, nb, nd, to);
      total++; if (to || nd !== 1 || nb !== exp_q.size())
        begin bad++; $display("FAIL rnd%0d_count: beats %0d pulses %0d timeout %0d want %0d beats 1 pulse", r, nb, nd, to, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < nb; i++) begin
        total++;
        if (got_q[gb+i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_beat[%0d]: got %0d/%0d want %0d/%0d", r, i, got_q[gb+i][19:4], got_q[gb+i][3:0], exp_q[i][19:4], exp_q[i][3:0]); end
      end
    end
    total++; if (int'(drop_count) !== m_drops) begin bad++; $display("FAIL rnd_drops: got %0d want %0d", drop_count, m_drops); end
  endtask

  task automatic test_repeat_and_drop();
    int gb, nb, nd, db; bit to;
    run_round(mk(1, 50, 60, 1, 2), mk(0, 0, 0, 0, 0), 100, 0, gb, nb, nd, to);
    total++; if (to || nd !== 1 || nb !== 9) begin bad++; $display("FAIL rep_first: beats %0d pulses %0d want 9 beats 1 pulse", nb, nd); end
    run_round(mk(1, 50, 60, 1, 2), mk(0, 0, 0, 0, 0), 100, 0, gb, nb, nd, to);
    total++; if (to || nd !== 1 || nb !== 0) begin bad++; $display("FAIL rep_same: beats %0d pulses %0d want 0 beats 1 pulse", nb, nd); end
    model_round(mk(1, 70, 60, 11, 2), mk(0, 0, 0, 0, 0));
    gb = got_q.size(); db = done_cnt;
    set_inputs(mk(1, 70, 60, 11, 2), mk(0, 0, 0, 0, 0));
    wr_bus.wr_ready_in = 1'b0;
    nf = 1'b1; tick(); nf = 1'b0; scramble();
    for (int k = 0; k < 300; k++) begin
      nf = 1'b1; tick(); nf = 1'b0; tick();
    end
    m_drops = (m_drops + 300 > 255) ? 255 : m_drops + 300;
    total++; if (int'(drop_count) !== m_drops) begin bad++; $display("FAIL drop_sat: got %0d want %0d", drop_count, m_drops); end
    total++; if (got_q.size() !== gb) begin bad++; $display("FAIL drop_nobeat: got %0d beats while stalled want 0", got_q.size() - gb); end
    wr_bus.wr_ready_in = 1'b1;
    to = 1'b1;
    for (int c = 0; c < 500; c++) begin
      tick();
      if (done_cnt != db) begin to = 1'b0; break; end
    end
    repeat (3) tick();
    total++; if (to || done_cnt - db !== 1 || got_q.size() - gb !== exp_q.size())
      begin bad++; $display("FAIL drop_round: beats %0d pulses %0d want %0d beats 1 pulse", got_q.size() - gb, done_cnt - db, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && gb + i < got_q.size(); i++) begin
      total++;
      if (got_q[gb+i] !== exp_q[i]) begin bad++; $display("FAIL drop_beat[%0d]: got addr %0d want %0d", i, got_q[gb+i][19:4], exp_q[i][19:4]); end
    end
  endtask

  task automatic test_reset_mid();
    int gb, nb, nd; bit to;
    set_inputs(mk(1, 10, 10, 8, 2), mk(0, 0, 0, 0, 0));
    wr_bus.wr_ready_in = 1'b0;
    nf = 1'b1; tick(); nf = 1'b0; scramble();
    to = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (wr_bus.wr_en_out === 1'b1) begin to = 1'b0; break; end
      tick();
    end
    total++; if (to) begin bad++; $display("FAIL rmid_paint: no pending beat seen, want wr_en 1"); end
    rst = 1'b1;
    tick();
    total++; if (wr_bus.wr_en_out !== 1'b0) begin bad++; $display("FAIL rmid_wr_en: got %b want 0", wr_bus.wr_en_out); end
    total++; if (wr_bus.wr_addr_out !== 16'd0) begin bad++; $display("FAIL rmid_addr: got %0d want 0", wr_bus.wr_addr_out); end
    total++; if (wr_bus.wr_data_out !== 4'd0) begin bad++; $display("FAIL rmid_data: got %0d want 0", wr_bus.wr_data_out); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rmid_status: busy %b done %b want 0 0", busy, done); end
    total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL rmid_drop: got %0d want 0", drop_count); end
    rst = 1'b0; wr_bus.wr_ready_in = 1'b1;
    tick();
    model_reset();
    run_round(mk(1, 70, 60, 11, 2), mk(0, 0, 0, 0, 0), 100, 0, gb, nb, nd, to);
    total++; if (to || nd !== 1 || nb !== 9 || exp_q.size() !== 9)
      begin bad++; $display("FAIL rmid_repaint: beats %0d pulses %0d want 9 beats 1 pulse", nb, nd); end
    for (int i = 0; i < exp_q.size() && i < nb; i++) begin
      total++;
      if (got_q[gb+i] !== exp_q[i]) begin bad++; $display("FAIL rmid_beat[%0d]: got addr %0d want %0d", i, got_q[gb+i][19:4], exp_q[i][19:4]); end
    end
  endtask

  initial begin
    rst = 1'b0; nf = 1'b0; wr_bus.wr_ready_in = 1'b1;
    set_inputs(mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0));
    model_reset();
    test_reset();
    test_single();
    test_two_sources();
    test_clipping();
    test_backpressure();
    test_random();
    test_repeat_and_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
